// File: rtl/csa_pipe_adder.sv
// Pipelined signed carry-skip adder.
// Each pipeline stage resolves one BLOCK-bit group. The group carry is either
// skipped straight through when the whole group propagates, or taken from the
// ripple chain. Operands are skewed so group k meets carry c_k. Partial sums
// travel alongside, so all groups of one operation leave together. The whole
// pipe advances only when the output slot is free or being drained.
module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NUM_BLK = WIDTH / BLOCK;
  localparam int LAST    = NUM_BLK - 1;

  if (WIDTH % BLOCK != 0) begin : g_bad_block
    $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK");
  end

  // The pipe moves as a unit; it freezes only while a result waits downstream.
  assign ready_o = !valid_o || ready_i;

  // Stage gi holds:
  //   a_reg/b_reg : operand bits [WIDTH-1 : gi*BLOCK] still to be added (skew)
  //   acc_reg     : {c_gi, sum bits [gi*BLOCK-1:0]} already resolved (deskew)
  //   valid_reg   : whether this slot carries an operation or a bubble
  for (genvar gi = 0; gi < NUM_BLK; gi++) begin : stg
    localparam int LO = gi * BLOCK;
    localparam int OW = WIDTH - LO;
    localparam int AW = LO + 1;

    logic [OW-1:0]       a_reg;
    logic [OW-1:0]       b_reg;
    logic [AW-1:0]       acc_reg;
    logic                valid_reg;

    logic [BLOCK:0]      rc;
    logic [BLOCK-1:0]    grp_sum;
    logic [BLOCK-1:0]    grp_p;
    logic                c_skip;
    logic [AW+BLOCK-1:0] acc_nxt;

    assign rc[0] = acc_reg[AW-1];

    // Per-bit skip cells: sum, ripple carry and propagate for the low group.
    for (genvar gj = 0; gj < BLOCK; gj++) begin : bit_cell
      assign grp_p[gj]   = a_reg[gj] ^ b_reg[gj];
      assign grp_sum[gj] = grp_p[gj] ^ rc[gj];
      assign rc[gj+1]    = (a_reg[gj] & b_reg[gj]) | (grp_p[gj] & rc[gj]);
    end

    // Skip mux is steered by the group propagate only, never by the ripple result.
    assign c_skip = (&grp_p) ? rc[0] : rc[BLOCK];

    assign acc_nxt[AW+BLOCK-1 -: BLOCK+1] = {c_skip, grp_sum};
    if (gi > 0) begin : g_lo
      assign acc_nxt[LO-1:0] = acc_reg[LO-1:0];
    end

    if (gi == 0) begin : g_load
      // Capture a new operation (or a bubble) whenever the pipe advances.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_reg     <= '0;
          b_reg     <= '0;
          acc_reg   <= '0;
          valid_reg <= 1'b0;
        end else if (ready_o) begin
          a_reg     <= a_i;
          b_reg     <= b_i;
          acc_reg   <= cin_i;
          valid_reg <= valid_i;
        end
      end
    end else begin : g_load
      // Take the previous stage's remaining operands and resolved partial sum.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_reg     <= '0;
          b_reg     <= '0;
          acc_reg   <= '0;
          valid_reg <= 1'b0;
        end else if (ready_o) begin
          a_reg     <= stg[gi-1].a_reg[OW+BLOCK-1:BLOCK];
          b_reg     <= stg[gi-1].b_reg[OW+BLOCK-1:BLOCK];
          acc_reg   <= stg[gi-1].acc_nxt;
          valid_reg <= stg[gi-1].valid_reg;
        end
      end
    end
  end

  // Output slot: the last stage's full result, held while downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      sum_o   <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (ready_o) begin
      valid_o <= stg[LAST].valid_reg;
      sum_o   <= stg[LAST].acc_nxt[WIDTH-1:0];
      cout_o  <= stg[LAST].acc_nxt[WIDTH];
      // Overflow: carry into the MSB disagrees with the carry out of it.
      ovf_o   <= stg[LAST].rc[BLOCK-1] ^ stg[LAST].c_skip;
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed corner cases, random ops under a
// toggling ready_i, and a mid-flight reset, all checked through a scoreboard.
module tb_csa_pipe_adder;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         ovf_o;

  csa_pipe_adder #(.WIDTH(W), .BLOCK(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .a_i    (a_i),
    .b_i    (b_i),
    .cin_i  (cin_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .sum_o  (sum_o),
    .cout_o (cout_o),
    .ovf_o  (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  bit           check_lat = 1'b0;
  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: widen, add, then derive flags from operand and result signs.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {v, full[W], s};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshake rule, stall stability, pop/compare, push on accept.
  bit           hold_prev = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      check_val("ready_o", 32'(ready_o), 32'(!valid_o || ready_i));
      if (hold_prev) begin
        check_val("hold_valid", 32'(valid_o), 32'd1);
        check_val("hold_sum", 32'(sum_o), 32'(prev_sum));
        check_val("hold_cout", 32'(cout_o), 32'(prev_cout));
        check_val("hold_ovf", 32'(ovf_o), 32'(prev_ovf));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check_val("extra_out", 32'(valid_o), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("result sum=%h cout=%b ovf=%b (exp %h %b %b)",
                   sum_o, cout_o, ovf_o, e.sum, e.cout, e.ovf);
          check_val("sum", 32'(sum_o), 32'(e.sum));
          check_val("cout", 32'(cout_o), 32'(e.cout));
          check_val("ovf", 32'(ovf_o), 32'(e.ovf));
          if (e.lat) check_val("latency", 32'(cyc - e.cyc - 1), 32'(LAT));
        end
      end
      hold_prev = valid_o && !ready_i;
      prev_sum  = sum_o;
      prev_cout = cout_o;
      prev_ovf  = ovf_o;
      if (valid_i && ready_o) begin
        exp_t n;
        n.sum  = exp_sum;
        n.cout = exp_cout;
        n.ovf  = exp_ovf;
        n.cyc  = cyc;
        n.lat  = check_lat;
        exp_q.push_back(n);
      end
    end
  end

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    a_i      = a;
    b_i      = b;
    cin_i    = c;
    exp_sum  = es;
    exp_cout = ec;
    exp_ovf  = eo;
    valid_i  = 1'b1;
  endtask

  task automatic set_rand_op();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W+1:0] r;
    a = W'($urandom);
    b = W'($urandom);
    c = 1'($urandom);
    r = ref_add(a, b, c);
    set_op(a, b, c, r[W-1:0], r[W], r[W+1]);
  endtask

  // One op per cycle with ready_i held high (always accepted).
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    set_op(a, b, c, es, ec, eo);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int sent;
    int k;
    bit acc;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    a_i = '0; b_i = '0; cin_i = 1'b0;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_val("rst_valid_o", 32'(valid_o), 32'd0);
    check_val("rst_sum_o", 32'(sum_o), 32'd0);
    check_val("rst_cout_o", 32'(cout_o), 32'd0);
    check_val("rst_ovf_o", 32'(ovf_o), 32'd0);
    @(posedge clk); #1;

    // Directed corner cases, back to back, fixed latency.
    check_lat = 1'b1;
    drive_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    drive_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    drive_op(16'h1234, 16'hEDCB, 1'b1, 16'h0000, 1'b1, 1'b0);
    drive_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    idle(8);
    check_val("directed_drain", 32'(exp_q.size()), 32'd0);

    // Random ops with ready_i cycling 1,0,0,1.
    check_lat = 1'b0;
    sent = 0;
    k = 0;
    set_rand_op();
    while (sent < 8 && k < 200) begin
      ready_i = pat[k % 4];
      @(negedge clk);
      acc = ready_o;
      @(posedge clk); #1;
      k++;
      if (acc) begin
        sent++;
        if (sent < 8) set_rand_op();
      end
    end
    check_val("rand_sent", 32'(sent), 32'd8);
    valid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ready_i = pat[(k + i) % 4];
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    idle(6);
    check_val("rand_drain", 32'(exp_q.size()), 32'd0);

    // Three ops in flight, then a one-cycle reset discards them.
    for (int i = 0; i < 3; i++) begin
      set_rand_op();
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_val("post_rst_valid", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    idle(8);
    check_lat = 1'b1;
    drive_op(16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);
    idle(8);
    check_val("post_rst_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
